// File: rtl/xbar_pkg.sv
// Shared definitions for the N x M crossbar: command encodings, slave-port
// FSM states and a constant-evaluable log2 helper used for derived widths.
package xbar_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } xbar_state_e;

   // Ceiling log2; returns 0 for value <= 1, so callers clamp to a minimum of 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting master at
// or after ptr_i, wrapping cyclically. One instance per slave port.
module xbar_rr_arbiter
   import xbar_pkg::*;
#(
   parameter  int N_M = 2,
   localparam int GW  = (clog2(N_M) < 1) ? 1 : clog2(N_M)
) (
   input  logic [N_M-1:0] req_i,
   input  logic [GW-1:0]  ptr_i,
   output logic [GW-1:0]  grant_o,
   output logic           valid_o
);

   // Two passes: first the masters at/after the pointer, then the wrapped ones.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N_M; i++) begin
         if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
            valid_o = 1'b1;
            grant_o = GW'(i);
         end
      end
      for (int i = 0; i < N_M; i++) begin
         if (!valid_o && req_i[i] && (i < int'(ptr_i))) begin
            valid_o = 1'b1;
            grant_o = GW'(i);
         end
      end
   end

endmodule

// File: rtl/crossbar_nxm.sv
// Parametrised N-master x M-slave crossbar. The top address bits pick the
// slave; each slave port runs its own IDLE/BUSY FSM with a round-robin
// pointer, so distinct slaves serve distinct masters concurrently. Requests
// to a non-existent slave are answered by a registered decode-error path.
module crossbar_nxm
   import xbar_pkg::*;
#(
   parameter int N_M = 2,
   parameter int N_S = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_M-1:0]    master_req,
   input  logic [N_M-1:0]    master_cmd,
   input  logic [N_M*AW-1:0] master_addr,
   input  logic [N_M*DW-1:0] master_wdata,
   output logic [N_M*DW-1:0] master_rdata,
   output logic [N_M-1:0]    master_ack,
   output logic [N_M-1:0]    master_err,
   output logic [N_S-1:0]    slave_req,
   output logic [N_S-1:0]    slave_cmd,
   output logic [N_S*AW-1:0] slave_addr,
   output logic [N_S*DW-1:0] slave_wdata,
   input  logic [N_S*DW-1:0] slave_rdata,
   input  logic [N_S-1:0]    slave_ack
);

   localparam int SEL_W = (clog2(N_S) < 1) ? 1 : clog2(N_S);
   localparam int GW    = (clog2(N_M) < 1) ? 1 : clog2(N_M);

   logic [SEL_W-1:0] tgt [N_M];
   logic [N_M-1:0]   bad;
   logic [N_M-1:0]   held;
   logic [N_M-1:0]   err_ack_q;
   logic [N_M-1:0]   err_ack_d;
   xbar_state_e      state_q [N_S];
   logic [GW-1:0]    grant_q [N_S];
   logic [GW-1:0]    rr_q    [N_S];
   logic [N_S-1:0]   done;

   genvar gi;

   // Address decode: slave index from the MSBs, flag indices with no slave.
   for (gi = 0; gi < N_M; gi++) begin : g_decode
      assign tgt[gi] = master_addr[gi*AW + AW - 1 -: SEL_W];
      assign bad[gi] = ({1'b0, tgt[gi]} >= (SEL_W+1)'(N_S));
   end

   // Masters currently owned by some BUSY slave port.
   always_comb begin
      held = '0;
      for (int s = 0; s < N_S; s++) begin
         for (int i = 0; i < N_M; i++) begin
            if ((state_q[s] == BUSY) && (grant_q[s] == GW'(i))) begin
               held[i] = 1'b1;
            end
         end
      end
   end

   // Error responder: pulse once per decode-error request; the cycle spent
   // acking masks the still-held req so it is not answered twice.
   assign err_ack_d = master_req & bad & ~err_ack_q;

   // Decode-error pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ack_q <= '0;
      end else begin
         err_ack_q <= err_ack_d;
      end
   end

   for (gi = 0; gi < N_S; gi++) begin : g_slave
      logic [N_M-1:0] cand;
      logic [GW-1:0]  arb_grant;
      logic           arb_valid;
      xbar_state_e    state_d;
      logic [GW-1:0]  grant_d;
      logic [GW-1:0]  rr_d;

      // Candidates: requesting masters aimed at this port and not owned elsewhere.
      always_comb begin
         cand = '0;
         for (int i = 0; i < N_M; i++) begin
            cand[i] = master_req[i] && !bad[i] && !held[i] && (tgt[i] == SEL_W'(gi));
         end
      end

      xbar_rr_arbiter #(
         .N_M (N_M)
      ) u_arb (
         .req_i   (cand),
         .ptr_i   (rr_q[gi]),
         .grant_o (arb_grant),
         .valid_o (arb_valid)
      );

      // Port FSM: latch a winner in IDLE, release and advance pointer on ack.
      always_comb begin
         state_d = state_q[gi];
         grant_d = grant_q[gi];
         rr_d    = rr_q[gi];
         case (state_q[gi])
            IDLE: begin
               if (arb_valid) begin
                  state_d = BUSY;
                  grant_d = arb_grant;
               end
            end
            BUSY: begin
               if (slave_ack[gi]) begin
                  state_d = IDLE;
                  rr_d    = (grant_q[gi] == GW'(N_M - 1)) ? '0 : grant_q[gi] + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Port state, grant and round-robin pointer registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q[gi] <= IDLE;
            grant_q[gi] <= '0;
            rr_q[gi]    <= '0;
         end else begin
            state_q[gi] <= state_d;
            grant_q[gi] <= grant_d;
            rr_q[gi]    <= rr_d;
         end
      end

      assign done[gi] = (state_q[gi] == BUSY) && slave_ack[gi];
   end

   // Slave-side mux: a BUSY port forwards its granted master's live inputs.
   always_comb begin
      slave_req   = '0;
      slave_cmd   = '0;
      slave_addr  = '0;
      slave_wdata = '0;
      for (int s = 0; s < N_S; s++) begin
         if (state_q[s] == BUSY) begin
            slave_req[s] = 1'b1;
            for (int i = 0; i < N_M; i++) begin
               if (grant_q[s] == GW'(i)) begin
                  slave_cmd[s]             = master_cmd[i];
                  slave_addr[s*AW +: AW]   = master_addr[i*AW +: AW];
                  slave_wdata[s*DW +: DW]  = master_wdata[i*DW +: DW];
               end
            end
         end
      end
   end

   // Master-side return path: slave ack/rdata routed back in the same cycle.
   always_comb begin
      master_ack   = err_ack_q;
      master_err   = err_ack_q;
      master_rdata = '0;
      for (int s = 0; s < N_S; s++) begin
         if (done[s]) begin
            for (int i = 0; i < N_M; i++) begin
               if (grant_q[s] == GW'(i)) begin
                  master_ack[i]             = 1'b1;
                  master_rdata[i*DW +: DW]  = slave_rdata[s*DW +: DW];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_crossbar_nxm.sv
// Bench for crossbar_nxm: a 2x2 instance for arbitration/concurrency/reset
// and a 2x3 instance for decode errors. Expected master acks are queued when
// stimulus is driven and retired by a monitor when the DUT acks.
module tb_crossbar_nxm;
   import xbar_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // 2x2 instance
   logic [1:0]  a_mreq, a_mcmd, a_mack, a_merr, a_sreq, a_scmd, a_sack;
   logic [63:0] a_maddr, a_mwdata, a_mrdata, a_saddr, a_swdata, a_srdata;
   // 2x3 instance
   logic [1:0]  b_mreq, b_mcmd, b_mack, b_merr;
   logic [2:0]  b_sreq, b_scmd, b_sack;
   logic [63:0] b_maddr, b_mwdata, b_mrdata;
   logic [95:0] b_saddr, b_swdata, b_srdata;

   crossbar_nxm #(.N_M(2), .N_S(2), .AW(32), .DW(32)) u_dut (
      .clk (clk), .rst_n (rst_n),
      .master_req (a_mreq), .master_cmd (a_mcmd), .master_addr (a_maddr),
      .master_wdata (a_mwdata), .master_rdata (a_mrdata), .master_ack (a_mack),
      .master_err (a_merr), .slave_req (a_sreq), .slave_cmd (a_scmd),
      .slave_addr (a_saddr), .slave_wdata (a_swdata), .slave_rdata (a_srdata),
      .slave_ack (a_sack)
   );

   crossbar_nxm #(.N_M(2), .N_S(3), .AW(32), .DW(32)) u_dut3 (
      .clk (clk), .rst_n (rst_n),
      .master_req (b_mreq), .master_cmd (b_mcmd), .master_addr (b_maddr),
      .master_wdata (b_mwdata), .master_rdata (b_mrdata), .master_ack (b_mack),
      .master_err (b_merr), .slave_req (b_sreq), .slave_cmd (b_scmd),
      .slave_addr (b_saddr), .slave_wdata (b_swdata), .slave_rdata (b_srdata),
      .slave_ack (b_sack)
   );

   typedef struct {
      int          inst;
      int          m;
      int          at;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic expect_ack(input int inst, input int m, input int at,
                             input logic [31:0] rd, input logic er);
      exp_t e;
      e.inst  = inst;
      e.m     = m;
      e.at    = at;
      e.rdata = rd;
      e.err   = er;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: every master ack must match a queued entry for this cycle,
   // and every entry due this cycle must see its ack.
   int          mon_idx;
   logic        mon_ack, mon_err;
   logic [31:0] mon_rd;
   initial forever begin
      @(negedge clk);
      for (int inst = 0; inst < 2; inst++) begin
         for (int m = 0; m < 2; m++) begin
            if (inst == 0) begin
               mon_ack = a_mack[m];
               mon_err = a_merr[m];
               mon_rd  = a_mrdata[m*32 +: 32];
            end else begin
               mon_ack = b_mack[m];
               mon_err = b_merr[m];
               mon_rd  = b_mrdata[m*32 +: 32];
            end
            mon_idx = -1;
            for (int k = 0; k < sb_q.size(); k++) begin
               if (sb_q[k].inst == inst && sb_q[k].m == m && sb_q[k].at == cyc) mon_idx = k;
            end
            if (mon_ack) begin
               $display("ack inst=%0d master=%0d cyc=%0d rdata=%h err=%b", inst, m, cyc, mon_rd, mon_err);
               if (mon_idx < 0) begin
                  check("unexpected_ack", {63'd0, mon_ack}, 64'd0);
               end else begin
                  check("ack_rdata", {32'd0, mon_rd}, {32'd0, sb_q[mon_idx].rdata});
                  check("ack_err", {63'd0, mon_err}, {63'd0, sb_q[mon_idx].err});
                  sb_q.delete(mon_idx);
               end
            end else if (mon_idx >= 0) begin
               check("missing_ack", {63'd0, mon_ack}, 64'd1);
               sb_q.delete(mon_idx);
            end
         end
      end
   end

   int n;
   int exp_m;

   initial begin
      a_mreq = '0; a_mcmd = '0; a_maddr = '0; a_mwdata = '0; a_srdata = '0; a_sack = '0;
      b_mreq = '0; b_mcmd = '0; b_maddr = '0; b_mwdata = '0; b_srdata = '1; b_sack = '0;

      // Reset state
      step(); step();
      sample();
      check("rst_sreq",   {62'd0, a_sreq}, 64'd0);
      check("rst_mack",   {62'd0, a_mack}, 64'd0);
      check("rst_merr",   {62'd0, a_merr}, 64'd0);
      check("rst_scmd",   {62'd0, a_scmd}, 64'd0);
      check("rst_saddr",  a_saddr, 64'd0);
      check("rst_swdata", a_swdata, 64'd0);
      check("rst_mrdata", a_mrdata, 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Two masters to S0: M0 read first (ptr 0), then M1 write after a bubble
      a_mreq   = 2'b11;
      a_mcmd   = {CMD_WRITE, CMD_READ};
      a_maddr  = {32'h0000_0ADD, 32'h0000_0ADD};
      a_mwdata = {32'h000F_EED1, 32'h0000_0000};
      step();
      a_sack[0] = 1'b1;
      a_srdata[31:0] = 32'hFEED_00C0;
      expect_ack(0, 0, cyc, 32'hFEED_00C0, 1'b0);
      sample();
      check("t1_sreq",  {62'd0, a_sreq}, 64'd1);
      check("t1_scmd",  {63'd0, a_scmd[0]}, {63'd0, CMD_READ});
      check("t1_saddr", {32'd0, a_saddr[31:0]}, 64'h0ADD);
      step();
      a_sack = '0;
      a_mreq[0] = 1'b0;
      sample();
      check("t1_bubble", {62'd0, a_sreq}, 64'd0);
      step();
      a_sack[0] = 1'b1;
      a_srdata[31:0] = 32'h1111_2222;
      expect_ack(0, 1, cyc, 32'h1111_2222, 1'b0);
      sample();
      check("t1_sreq2",  {62'd0, a_sreq}, 64'd1);
      check("t1_scmd2",  {63'd0, a_scmd[0]}, {63'd0, CMD_WRITE});
      check("t1_swdata", {32'd0, a_swdata[31:0]}, 64'h000F_EED1);
      step();
      a_sack = '0;
      a_mreq = '0;

      // Concurrent: M0 -> S1, M1 -> S0; S0 acks 2 cycles later, S1 4 cycles later
      a_mreq  = 2'b11;
      a_mcmd  = '0;
      a_maddr = {32'h0000_0ADD, 32'h8000_0ADD};
      step();
      sample();
      check("t2_sreq",   {62'd0, a_sreq}, 64'd3);
      check("t2_saddr1", {32'd0, a_saddr[63:32]}, 64'h8000_0ADD);
      check("t2_saddr0", {32'd0, a_saddr[31:0]}, 64'h0000_0ADD);
      step();
      step();
      a_sack[0] = 1'b1;
      a_srdata[31:0] = 32'hAAAA_0001;
      expect_ack(0, 1, cyc, 32'hAAAA_0001, 1'b0);
      step();
      a_sack[0] = 1'b0;
      a_mreq[1] = 1'b0;
      step();
      a_sack[1] = 1'b1;
      a_srdata[63:32] = 32'hBBBB_0002;
      expect_ack(0, 0, cyc, 32'hBBBB_0002, 1'b0);
      step();
      a_sack = '0;
      a_mreq = '0;

      // Fairness: both masters hammer S0, grants must alternate 0,1,0,1,0,1
      a_mreq  = 2'b11;
      a_mcmd  = '0;
      a_maddr = {32'h0000_0020, 32'h0000_0010};
      n = 0;
      for (int t = 0; t < 40 && n < 6; t++) begin
         step();
         if (a_sreq[0]) begin
            exp_m = n % 2;
            check("t3_grant", {32'd0, a_saddr[31:0]}, (exp_m == 1) ? 64'h20 : 64'h10);
            a_sack[0] = 1'b1;
            a_srdata[31:0] = 32'hC0DE_0000 + 32'(n);
            expect_ack(0, exp_m, cyc, 32'hC0DE_0000 + 32'(n), 1'b0);
            n++;
         end else begin
            a_sack[0] = 1'b0;
         end
      end
      check("t3_count", 64'(n), 64'd6);
      step();
      a_sack = '0;
      a_mreq = '0;

      // Decode error on the 3-slave instance: top bits 2'b11
      b_mreq[0] = 1'b1;
      b_mcmd[0] = CMD_READ;
      b_maddr[31:0] = 32'hC000_0000;
      expect_ack(1, 0, cyc + 1, 32'h0, 1'b1);
      sample();
      check("t4_sreq_a", {61'd0, b_sreq}, 64'd0);
      step();
      sample();
      check("t4_sreq_b", {61'd0, b_sreq}, 64'd0);
      step();
      b_mreq = '0;
      sample();
      check("t4_sreq_c", {61'd0, b_sreq}, 64'd0);
      // Legal access to S2 on the same instance
      b_mreq[1] = 1'b1;
      b_mcmd[1] = CMD_WRITE;
      b_maddr[63:32] = 32'h8000_0004;
      b_mwdata[63:32] = 32'h0000_5A5A;
      b_srdata[95:64] = 32'h2222_3333;
      step();
      sample();
      check("t4_s2_req",  {61'd0, b_sreq}, 64'd4);
      check("t4_s2_addr", {32'd0, b_saddr[95:64]}, 64'h8000_0004);
      check("t4_s2_wdat", {32'd0, b_swdata[95:64]}, 64'h5A5A);
      step();
      b_sack[2] = 1'b1;
      expect_ack(1, 1, cyc, 32'h2222_3333, 1'b0);
      step();
      b_sack = '0;
      b_mreq = '0;

      // Reset mid-transaction: slave_req drops at once, late ack is ignored
      a_mreq[0] = 1'b1;
      a_mcmd = '0;
      a_maddr[31:0] = 32'h0000_0100;
      step();
      sample();
      check("t5_busy", {62'd0, a_sreq}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_sreq", {62'd0, a_sreq}, 64'd0);
      a_mreq = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      a_sack[0] = 1'b1;
      sample();
      check("t5_late_sreq", {62'd0, a_sreq}, 64'd0);
      step();
      a_sack = '0;

      // slave_ack[1] with nothing pending: no ack, port stays IDLE
      a_sack[1] = 1'b1;
      step();
      a_sack = '0;
      sample();
      check("t6_idle", {62'd0, a_sreq}, 64'd0);
      a_mreq[1] = 1'b1;
      a_maddr[63:32] = 32'h8000_0008;
      a_srdata[63:32] = 32'h600D_0006;
      step();
      sample();
      check("t6_s1_req", {62'd0, a_sreq}, 64'd2);
      step();
      a_sack[1] = 1'b1;
      expect_ack(0, 1, cyc, 32'h600D_0006, 1'b0);
      step();
      a_sack = '0;
      a_mreq = '0;
      step();
      step();

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
